act_collect: RTL and testbench
==============================

# act_collect

Downstream stage of the 4-input 12-bit neuron MAC. Consumes the neuron's one-cycle `result_ready`/`result` pulses and applies ReLU. Requantizes each 12-bit signed sum to a 5-bit activation with round-half-up and saturation, then packs NUM_OUT consecutive activations into one vector for the next layer. Handshake on the output side is valid/ready. The input side has no backpressure, so a double buffer (collect bank + hold bank) absorbs one stalled vector; anything beyond that is dropped and flagged.

## Interface
- NUM_OUT, 4: activations per output vector (≥2)
- SHIFT, 3: right-shift applied after ReLU (0..8); SHIFT=0 disables rounding
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- result_ready  in  1  one-cycle strobe, `result` valid
- result  in  12  signed neuron sum
- out_ready  in  1  consumer accepts vector this cycle
- vec_valid  out  1  vec_data holds a complete vector
- vec_data  out  5*NUM_OUT  element k at bits [5k+4:5k], element 0 = first received
- overflow  out  1  sticky: an activation was dropped

## Operation
- Quantize (stage Q, registered):
  - r = (result < 0) ? 0 : result.
  - t = (r + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT, using a 13-bit unsigned intermediate.
  - q = min(t, 15); the activation is always non-negative, 0..15.
  - q_vld <= result_ready; q_val <= q.
- Collect:
  - idx counts 0..NUM_OUT-1; collect_full flag.
  - accept = q_vld && (!collect_full || xfer).
  - On accept: bank[idx] <= q_val. If idx == NUM_OUT-1: idx <= 0 and collect_full <= 1; else idx++.
- Transfer: xfer = collect_full && (!vec_valid || out_ready).
  - On xfer: hold <= bank (pre-write contents), vec_valid <= 1, collect_full <= 0, unless accept in the same cycle completes a new vector (only possible when NUM_OUT==1, which is excluded).
- Output:
  - If vec_valid && out_ready && !xfer: vec_valid <= 0.
  - vec_data = hold. It is stable while vec_valid && !out_ready.
- Overflow: q_vld && collect_full && !xfer → activation discarded, idx unchanged, overflow <= 1. overflow clears only on rst.
- Same cycle xfer + accept: accepted value lands in bank[0] of the new vector. hold takes the completed vector. No loss.
- Reset:
  - vec_valid=0, vec_data=0, overflow=0, q_vld=0, idx=0, collect_full=0, banks=0.
  - A partial vector in progress at reset is discarded.

## Timing
- Strobe for the last element in cycle t:
  - q_vld in t+1.
  - collect_full in t+2.
  - vec_valid in t+3 if hold is free.
- Minimum latency is 3 cycles.
- Sustained throughput: one activation per cycle with out_ready=1; no bubbles required.
- Buffering: one complete vector in hold plus one complete vector in bank. The first activation of a third vector overflows if hold is still stalled.
- All outputs registered; no combinational path from in to out.

## Structure
- Package nn_pkg holds:
  - ACC_W=12, ACT_W=5, ACT_MAX=15.
  - typedef logic signed [ACC_W-1:0] acc_t.
  - typedef logic [ACT_W-1:0] act_t.
  - The same typedefs are reused by the neuron stage.
- Sub-module relu_quant (combinational acc_t→act_t, parameter SHIFT): ReLU, round, saturate. Instantiated once ahead of the Q register; tested standalone.
- Top act_collect: Q register, idx counter, bank/hold arrays, flags.

## Test plan
- Reset: hold rst 2 cycles → vec_valid=0, overflow=0, vec_data=0; no vector emitted without inputs.
- SHIFT=3, out_ready=1, strobes 100, -50, 7, 2047 on consecutive cycles → elements {13,0,1,15}; vec_valid exactly 3 cycles after the 2047 strobe, for 1 cycle.
- Rounding boundaries, SHIFT=3: 3→0, 4→1, 123→15, 124→15 (sat), -2048→0; SHIFT=0: 15→15, 16→15.
- Backpressure: out_ready=0, send vectors A then B back-to-back.
  - A is held stable; B sits in collect_full.
  - The next strobe sets overflow=1 and is dropped.
  - Then out_ready=1 → A consumed, B presented the following cycle, overflow stays 1.
- Simultaneous: collect_full=1 and vec_valid=1 with out_ready=1, plus a strobe arriving → transfer happens, strobe value becomes element 0 of the next vector, overflow stays 0.
- Reset mid-vector: 2 strobes, rst 1 cycle, then 4 strobes (8, 16, 24, 32) → one vector {1,2,3,4}; no stale elements.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared widths and types for the neuron datapath: accumulator sums and
// requantized activations. Used by the MAC stage and by act_collect.
package nn_pkg;

  localparam int ACC_W   = 12;
  localparam int ACT_W   = 5;
  localparam int ACT_MAX = 15;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [ACT_W-1:0] act_t;

endpackage

// File: rtl/relu_quant.sv
// Combinational ReLU, round-half-up right shift and saturation that maps a
// signed accumulator sum to a non-negative activation in 0..ACT_MAX.
module relu_quant
  import nn_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  acc_t acc_i,
  output act_t act_o
);

  localparam int             EXT_W   = ACC_W + 1;
  localparam int             RND_INT = (1 << SHIFT) >> 1;
  localparam logic [EXT_W-1:0] RND   = EXT_W'(RND_INT);
  localparam logic [EXT_W-1:0] SAT   = EXT_W'(ACT_MAX);

  logic [EXT_W-1:0] relu;
  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] shifted;

  // The extra headroom bit keeps 2047 plus the rounding constant from wrapping.
  always_comb begin
    relu    = '0;
    sum     = '0;
    shifted = '0;
    act_o   = '0;
    relu    = acc_i[ACC_W-1] ? '0 : {1'b0, acc_i};
    sum     = relu + RND;
    shifted = sum >> SHIFT;
    act_o   = (shifted > SAT) ? ACT_W'(ACT_MAX) : shifted[ACT_W-1:0];
  end

endmodule

// File: rtl/act_collect.sv
// Quantizes neuron result pulses and packs NUM_OUT consecutive activations
// into a valid/ready vector, with a collect bank and a hold bank for slack.
module act_collect
  import nn_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int SHIFT   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     result_ready,
  input  logic [ACC_W-1:0]         result,
  input  logic                     out_ready,
  output logic                     vec_valid,
  output logic [ACT_W*NUM_OUT-1:0] vec_data,
  output logic                     overflow
);

  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  act_t q_act;

  logic                     q_vld_q,   q_vld_d;
  act_t                     q_val_q,   q_val_d;
  logic [IDX_W-1:0]         idx_q,     idx_d;
  logic                     full_q,    full_d;
  act_t                     bank_q [NUM_OUT];
  act_t                     bank_d [NUM_OUT];
  logic [ACT_W*NUM_OUT-1:0] hold_q,    hold_d;
  logic                     vld_q,     vld_d;
  logic                     ovf_q,     ovf_d;

  logic xfer;
  logic accept;

  relu_quant #(
    .SHIFT (SHIFT)
  ) u_relu_quant (
    .acc_i (acc_t'(result)),
    .act_o (q_act)
  );

  // A full collect bank may only drain into hold when hold is empty or is
  // being consumed this very cycle; otherwise a new activation has nowhere to go.
  assign xfer   = full_q && (!vld_q || out_ready);
  assign accept = q_vld_q && (!full_q || xfer);

  always_comb begin
    q_vld_d = result_ready;
    q_val_d = q_act;
    idx_d   = idx_q;
    full_d  = full_q;
    bank_d  = bank_q;
    hold_d  = hold_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;

    if (xfer) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        hold_d[k*ACT_W +: ACT_W] = bank_q[k];
      end
      vld_d  = 1'b1;
      full_d = 1'b0;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    // With NUM_OUT >= 2 an accept during xfer lands at index 0 and can
    // never re-complete a vector, so the full flag set here cannot collide.
    if (accept) begin
      bank_d[idx_q] = q_val_q;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (q_vld_q && full_q && !xfer) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld_q <= 1'b0;
      q_val_q <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      q_vld_q <= q_vld_d;
      q_val_q <= q_val_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < NUM_OUT; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign vec_valid = vld_q;
  assign vec_data  = hold_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_act_collect.sv
// Directed self-checking bench for act_collect (NUM_OUT=4, SHIFT=3) and for
// standalone relu_quant instances at SHIFT=3 and SHIFT=0.
module tb_act_collect;

  logic        clk;
  logic        rst;
  logic        resultReady;
  logic [11:0] result;
  logic        outReady;
  logic        vecValid;
  logic [19:0] vecData;
  logic        overflow;

  logic signed [11:0] rqIn;
  logic [4:0]         rqOut3;
  logic [4:0]         rqOut0;

  int assertCount = 0;
  int failCount   = 0;

  act_collect #(
    .NUM_OUT (4),
    .SHIFT   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_ready (resultReady),
    .result       (result),
    .out_ready    (outReady),
    .vec_valid    (vecValid),
    .vec_data     (vecData),
    .overflow     (overflow)
  );

  relu_quant #(.SHIFT(3)) rq3 (.acc_i(rqIn), .act_o(rqOut3));
  relu_quant #(.SHIFT(0)) rq0 (.acc_i(rqIn), .act_o(rqOut0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Element 0 sits in the least significant slice.
  function automatic logic [19:0] packVec(input logic [4:0] e0, input logic [4:0] e1,
                                          input logic [4:0] e2, input logic [4:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int value);
    resultReady = 1'b1;
    result      = 12'(value);
    waitCycle();
    resultReady = 1'b0;
  endtask

  task automatic applyVector(input int v0, input int v1, input int v2, input int v3);
    applyStimulus(v0);
    applyStimulus(v1);
    applyStimulus(v2);
    applyStimulus(v3);
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!vecValid && n < budget) begin
      waitCycle();
      n++;
    end
    if (!vecValid) checkOutput(tag, 32'(vecValid), 32'd1);
  endtask

  int q3In  [8] = '{3, 4, 123, 124, -2048, 100, 12, 7};
  int q3Exp [8] = '{0, 1, 15, 15, 0, 13, 2, 1};
  int q0In  [4] = '{15, 16, 0, -1};
  int q0Exp [4] = '{15, 15, 0, 0};

  initial begin
    rst         = 1'b0;
    resultReady = 1'b0;
    result      = '0;
    outReady    = 1'b1;
    rqIn        = '0;

    // Reset state and idle behaviour
    applyReset(2);
    checkOutput("reset_valid", 32'(vecValid), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_data", 32'(vecData), 32'd0);
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("idle_valid", 32'(vecValid), 32'd0);
    end

    // Standalone quantizer boundaries
    for (int i = 0; i < 8; i++) begin
      rqIn = 12'(q3In[i]);
      #1;
      checkOutput($sformatf("quant_s3_%0d", q3In[i]), 32'(rqOut3), 32'(q3Exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      rqIn = 12'(q0In[i]);
      #1;
      checkOutput($sformatf("quant_s0_%0d", q0In[i]), 32'(rqOut0), 32'(q0Exp[i]));
    end
    waitCycle();

    // Main vector and its 3-cycle latency
    applyVector(100, -50, 7, 2047);
    checkOutput("lat_t1_valid", 32'(vecValid), 32'd0);
    waitCycle();
    checkOutput("lat_t2_valid", 32'(vecValid), 32'd0);
    waitCycle();
    checkOutput("lat_t3_valid", 32'(vecValid), 32'd1);
    checkOutput("main_data", 32'(vecData), 32'(packVec(5'd13, 5'd0, 5'd1, 5'd15)));
    waitCycle();
    checkOutput("lat_t4_valid", 32'(vecValid), 32'd0);
    checkOutput("main_overflow", 32'(overflow), 32'd0);

    // Backpressure: A held, B parked in the collect bank, next one dropped
    outReady = 1'b0;
    applyVector(8, 16, 24, 32);
    applyVector(40, 48, 56, 64);
    waitCycle();
    waitCycle();
    checkOutput("bp_valid", 32'(vecValid), 32'd1);
    checkOutput("bp_hold_a", 32'(vecData), 32'(packVec(5'd1, 5'd2, 5'd3, 5'd4)));
    checkOutput("bp_no_ovf_yet", 32'(overflow), 32'd0);
    applyStimulus(80);
    waitCycle();
    checkOutput("bp_overflow", 32'(overflow), 32'd1);
    checkOutput("bp_a_stable", 32'(vecData), 32'(packVec(5'd1, 5'd2, 5'd3, 5'd4)));
    outReady = 1'b1;
    waitCycle();
    checkOutput("bp_b_valid", 32'(vecValid), 32'd1);
    checkOutput("bp_b_data", 32'(vecData), 32'(packVec(5'd5, 5'd6, 5'd7, 5'd8)));
    waitCycle();
    checkOutput("bp_drained", 32'(vecValid), 32'd0);
    checkOutput("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous transfer and accept
    applyReset(1);
    checkOutput("rst_clears_ovf", 32'(overflow), 32'd0);
    outReady = 1'b0;
    applyVector(8, 16, 24, 32);
    applyVector(40, 48, 56, 64);
    waitCycle();
    waitCycle();
    checkOutput("sim_hold_c", 32'(vecData), 32'(packVec(5'd1, 5'd2, 5'd3, 5'd4)));
    resultReady = 1'b1;
    result      = 12'd72;
    waitCycle();
    resultReady = 1'b0;
    outReady    = 1'b1;
    waitCycle();
    checkOutput("sim_valid", 32'(vecValid), 32'd1);
    checkOutput("sim_data_d", 32'(vecData), 32'(packVec(5'd5, 5'd6, 5'd7, 5'd8)));
    checkOutput("sim_no_ovf", 32'(overflow), 32'd0);
    waitCycle();
    checkOutput("sim_d_consumed", 32'(vecValid), 32'd0);
    applyStimulus(80);
    applyStimulus(88);
    applyStimulus(96);
    waitValid("sim_e_timeout", 10);
    checkOutput("sim_data_e", 32'(vecData), 32'(packVec(5'd9, 5'd10, 5'd11, 5'd12)));
    checkOutput("sim_ovf_final", 32'(overflow), 32'd0);
    waitCycle();

    // Reset in the middle of a partial vector
    applyStimulus(200);
    applyStimulus(300);
    applyReset(1);
    checkOutput("mid_rst_valid", 32'(vecValid), 32'd0);
    applyVector(8, 16, 24, 32);
    waitValid("mid_rst_timeout", 10);
    checkOutput("mid_rst_data", 32'(vecData), 32'(packVec(5'd1, 5'd2, 5'd3, 5'd4)));
    waitCycle();
    checkOutput("mid_rst_single", 32'(vecValid), 32'd0);
    checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
